// File: rtl/legacy_ingress_buf_pkg.sv
// Shared types and widths for the legacy ingress buffer slice.
package legacy_pkg;
  localparam int BYTE_W  = 8;
  localparam int FRAME_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/legacy_ingress_buf_if.sv
// Upstream byte handshake plus the paced output bus toward the legacy datapath.
interface legacy_ingress_buf_if
  import legacy_pkg::*;
#(
  parameter int AW = 4
);
  logic              s_valid;
  logic              s_ready;
  logic [BYTE_W-1:0] s_data;
  logic              s_last;
  logic              dn_en;
  logic              out_vld;
  logic [AW-1:0]     out_in0;
  logic [BYTE_W-1:0] out_in1;
  logic [7:3]        out_wpat1;
  logic [15:12]      out_wpat2;

  modport master (
    output s_valid, s_data, s_last, dn_en,
    input  s_ready, out_vld, out_in0, out_in1, out_wpat1, out_wpat2
  );

  modport slave (
    input  s_valid, s_data, s_last, dn_en,
    output s_ready, out_vld, out_in0, out_in1, out_wpat1, out_wpat2
  );
endinterface

// File: rtl/legacy_ingress_buf_sync_fifo.sv
// Small synchronous FIFO, no write-to-read bypass; clr empties it in one cycle.
module legacy_sync_fifo
  import legacy_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/legacy_ingress_buf.sv
// Buffers an upstream byte stream and paces it out to the legacy datapath,
// tagging each byte with its frame address and status patterns.
//
// state | meaning
// IDLE  | FIFO empty, waiting for a byte
// RUN   | popping one byte per dn_en
// GAP   | one-cycle bubble after a frame's last byte
module legacy_ingress_buf
  import legacy_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rstn,
  input logic                 clr,
  legacy_ingress_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic               pop;
  logic               full;
  logic               empty;
  logic [BYTE_W:0]    rdata;
  logic [CW-1:0]      count;
  logic               pop_last;
  logic [AW-1:0]      addr;
  logic [FRAME_W-1:0] frame_cnt;

  logic               out_vld;
  logic [AW-1:0]      out_in0;
  logic [BYTE_W-1:0]  out_in1;
  logic [4:0]         out_wpat1;
  logic [3:0]         out_wpat2;

  legacy_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (bus.s_valid & ~full),
    .pop   (pop),
    .wdata ({bus.s_last, bus.s_data}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop_last    = rdata[BYTE_W];
  assign bus.s_ready = ~full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) state_nxt = RUN;
      RUN: begin
        if (pop && pop_last) state_nxt = GAP;
        else if (empty)      state_nxt = IDLE;
      end
      GAP:     state_nxt = empty ? IDLE : RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == RUN) pop = bus.dn_en & ~empty;
  end

  // Fill level is captured before the pop takes effect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld   <= 1'b0;
      out_in0   <= '0;
      out_in1   <= '0;
      out_wpat1 <= '0;
      out_wpat2 <= '0;
      addr      <= '0;
      frame_cnt <= '0;
    end else if (clr) begin
      out_vld   <= 1'b0;
      out_in0   <= '0;
      out_in1   <= '0;
      out_wpat1 <= '0;
      out_wpat2 <= '0;
      addr      <= '0;
      frame_cnt <= '0;
    end else begin
      out_vld <= pop;
      if (pop) begin
        out_in1   <= rdata[BYTE_W-1:0];
        out_in0   <= addr;
        out_wpat1 <= {frame_cnt, pop_last};
        out_wpat2 <= 4'(count);
        if (pop_last) begin
          addr      <= '0;
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end else begin
          addr <= addr + AW'(1);
        end
      end
    end
  end

  assign bus.out_vld   = out_vld;
  assign bus.out_in0   = out_in0;
  assign bus.out_in1   = out_in1;
  assign bus.out_wpat1 = out_wpat1;
  assign bus.out_wpat2 = out_wpat2;
endmodule

// File: tb/tb_legacy_ingress_buf.sv
// Bench for legacy_ingress_buf: directed scenarios plus random traffic against a queue model.
module tb_legacy_ingress_buf;
  import legacy_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  logic clr;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  legacy_ingress_buf_if #(.AW(AW)) bus ();

  legacy_ingress_buf #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bus)
  );

  // Reference model: byte queue plus frame position bookkeeping.
  logic [8:0]    mq[$];
  int            m_mode;
  int            m_addr;
  int            m_frame;
  logic          m_vld;
  logic [AW-1:0] m_in0;
  logic [7:0]    m_in1;
  logic [4:0]    m_wp1;
  logic [3:0]    m_wp2;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_addr = 0; m_frame = 0;
    m_vld = 1'b0; m_in0 = '0; m_in1 = '0; m_wp1 = '0; m_wp2 = '0;
  endtask

  task automatic model_step();
    int         n;
    bit         push;
    bit         pop;
    logic [8:0] e;
    e = '0;
    if (clr) begin
      model_reset();
      return;
    end
    n    = mq.size();
    push = bus.s_valid && (n < DEPTH);
    pop  = (m_mode == 1) && bus.dn_en && (n > 0);
    m_vld = pop;
    if (pop) begin
      e     = mq.pop_front();
      m_in1 = e[7:0];
      m_in0 = AW'(m_addr);
      m_wp1 = {4'(m_frame), e[8]};
      m_wp2 = 4'(n);
      if (e[8]) begin
        m_addr  = 0;
        m_frame = (m_frame + 1) % 16;
      end else begin
        m_addr = (m_addr + 1) % (1 << AW);
      end
    end
    case (m_mode)
      0: if (n > 0) m_mode = 1;
      1: begin
        if (pop && e[8]) m_mode = 2;
        else if (n == 0) m_mode = 0;
      end
      default: m_mode = (n > 0) ? 1 : 0;
    endcase
    if (push) mq.push_back({bus.s_last, bus.s_data});
  endtask

  function automatic logic [22:0] exp_obs();
    return {(mq.size() < DEPTH), m_vld, m_in0, m_in1, m_wp1, m_wp2};
  endfunction

  function automatic logic [22:0] dut_obs();
    return {bus.s_ready, bus.out_vld, bus.out_in0, bus.out_in1, bus.out_wpat1, bus.out_wpat2};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(int n);
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.dn_en = 1'b0; clr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.dn_en = 1'b0;
    clr = 1'b0; rstn = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if (dut_obs() !== {1'b1, 22'b0}) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", dut_obs(), {1'b1, 22'b0});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
    end
  endtask

  task automatic test_frame();
    logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int         exp_t [4] = '{2, 3, 4, 6};
    logic [3:0] exp_in0 [4] = '{4'd0, 4'd1, 4'd2, 4'd0};
    logic [4:0] exp_wp1 [4] = '{5'b00000, 5'b00000, 5'b00001, 5'b00011};
    int         got_t [4];
    logic [3:0] got_in0 [4];
    logic [4:0] got_wp1 [4];
    logic [7:0] got_in1 [4];
    int         nv = 0;
    bus.dn_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.s_valid = (c < 4);
      bus.s_last  = (c == 2 || c == 3);
      if (c < 4) bus.s_data = dat[c];
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL frame c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (bus.out_vld === 1'b1 && nv < 4) begin
        got_t[nv] = c; got_in0[nv] = bus.out_in0; got_wp1[nv] = bus.out_wpat1;
        got_in1[nv] = bus.out_in1; nv++;
      end
    end
    n_vec++;
    if (nv !== 4) begin
      n_err++; $display("FAIL frame_count got=%0d exp=4", nv);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({got_t[i], got_in0[i], got_wp1[i], got_in1[i]} !== {exp_t[i], exp_in0[i], exp_wp1[i], dat[i]}) begin
        n_err++;
        $display("FAIL frame_byte%0d got t=%0d in0=%0d wp1=%b in1=%h exp t=%0d in0=%0d wp1=%b in1=%h",
                 i, got_t[i], got_in0[i], got_wp1[i], got_in1[i], exp_t[i], exp_in0[i], exp_wp1[i], dat[i]);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_frame();
    int  t_first = -1;
    logic [22:0] first = '0;
    bus.dn_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.s_valid = (c < 3); bus.s_data = 8'hA0 + 8'(c); bus.s_last = 1'b0;
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
    end
    bus.s_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (dut_obs() !== {1'b1, 22'b0}) begin
      n_err++; $display("FAIL midrst_async got=%h exp=%h", dut_obs(), {1'b1, 22'b0});
    end
    model_reset();
    @(posedge clk); #1;
    n_vec++;
    if (dut_obs() !== {1'b1, 22'b0}) begin
      n_err++; $display("FAIL midrst_held got=%h exp=%h", dut_obs(), {1'b1, 22'b0});
    end
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.s_valid = (c == 0); bus.s_data = 8'h5A; bus.s_last = 1'b1;
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL midrst_post c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (bus.out_vld === 1'b1 && t_first < 0) begin
        t_first = c; first = dut_obs();
      end
    end
    n_vec++;
    if ({t_first, first[20:0]} !== {32'd2, 4'd0, 8'h5A, 5'b00001, 4'd1}) begin
      n_err++; $display("FAIL midrst_first got t=%0d obs=%h exp t=2 in0=0 in1=5a wp1=00001", t_first, first);
    end
    idle_cycles(2);
  endtask

  task automatic test_fill();
    logic [7:0] b0;
    b0 = 8'($urandom);
    bus.dn_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.s_valid = 1'b1; bus.s_data = b0 + 8'(c); bus.s_last = (c == 3);
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL fill c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (c >= 3) begin
        n_vec++;
        if (bus.s_ready !== 1'b0) begin
          n_err++; $display("FAIL fill_ready c=%0d got=%b exp=0", c, bus.s_ready);
        end
      end
    end
    bus.s_valid = 1'b0; bus.dn_en = 1'b1;
    tick();
    n_vec++;
    if ({bus.out_vld, bus.out_wpat2, bus.out_in1, bus.s_ready} !== {1'b1, 4'd4, b0, 1'b1}) begin
      n_err++;
      $display("FAIL fill_pop got vld=%b wp2=%0d in1=%h rdy=%b exp vld=1 wp2=4 in1=%h rdy=1",
               bus.out_vld, bus.out_wpat2, bus.out_in1, bus.s_ready, b0);
    end
    bus.dn_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if ({bus.out_vld, bus.out_in1, bus.out_wpat2} !== {1'b0, b0, 4'd4}) begin
        n_err++; $display("FAIL fill_hold c=%0d got vld=%b in1=%h wp2=%0d exp vld=0 in1=%h wp2=4",
                          c, bus.out_vld, bus.out_in1, bus.out_wpat2, b0);
      end
    end
    bus.dn_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL fill_drain c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_wrap();
    int         got_t [18];
    logic [3:0] got_in0 [18];
    int         nv = 0;
    bus.dn_en = 1'b1;
    for (int c = 0; c < 24; c++) begin
      bus.s_valid = (c < 18); bus.s_data = 8'($urandom); bus.s_last = (c == 17);
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL wrap c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (bus.out_vld === 1'b1 && nv < 18) begin
        got_t[nv] = c; got_in0[nv] = bus.out_in0; nv++;
      end
    end
    n_vec++;
    if (nv !== 18) begin
      n_err++; $display("FAIL wrap_count got=%0d exp=18", nv);
    end
    for (int i = 0; i < 18; i++) begin
      n_vec++;
      if ({got_t[i], got_in0[i]} !== {32'(2 + i), 4'(i % 16)}) begin
        n_err++; $display("FAIL wrap_byte%0d got t=%0d in0=%0d exp t=%0d in0=%0d",
                          i, got_t[i], got_in0[i], 2 + i, i % 16);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_simul();
    logic [7:0] dat [4];
    bit         sv [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit         dn [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] exp_wp2 [4] = '{4'd2, 4'd2, 4'd2, 4'd1};
    logic [7:0] got_in1 [4];
    logic [3:0] got_wp2 [4];
    int         nv = 0;
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    for (int c = 0; c < 9; c++) begin
      bus.s_valid = sv[c]; bus.dn_en = dn[c]; bus.s_last = (c == 3);
      if (c < 4) bus.s_data = dat[c];
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL simul c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (bus.out_vld === 1'b1 && nv < 4) begin
        got_in1[nv] = bus.out_in1; got_wp2[nv] = bus.out_wpat2; nv++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({got_in1[i], got_wp2[i]} !== {dat[i], exp_wp2[i]}) begin
        n_err++; $display("FAIL simul_byte%0d got in1=%h wp2=%0d exp in1=%h wp2=%0d",
                          i, got_in1[i], got_wp2[i], dat[i], exp_wp2[i]);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_clr();
    int          t_first = -1;
    logic [22:0] first = '0;
    for (int c = 0; c < 3; c++) begin
      bus.s_valid = (c < 2); bus.s_data = 8'h60 + 8'(c); bus.s_last = 1'b0; bus.dn_en = (c == 2);
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL clr_pre c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
    end
    clr = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hEE; bus.dn_en = 1'b1;
    tick();
    n_vec++;
    if (dut_obs() !== {1'b1, 22'b0}) begin
      n_err++; $display("FAIL clr_outputs got=%h exp=%h", dut_obs(), {1'b1, 22'b0});
    end
    clr = 1'b0; bus.s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if ({bus.out_vld, bus.s_ready} !== 2'b01) begin
        n_err++; $display("FAIL clr_empty c=%0d got vld=%b rdy=%b exp vld=0 rdy=1", c, bus.out_vld, bus.s_ready);
      end
    end
    for (int c = 0; c < 5; c++) begin
      bus.s_valid = (c == 0); bus.s_data = 8'h3C; bus.s_last = 1'b1;
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL clr_post c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
      if (bus.out_vld === 1'b1 && t_first < 0) begin
        t_first = c; first = dut_obs();
      end
    end
    n_vec++;
    if (first[20:0] !== {4'd0, 8'h3C, 5'b00001, 4'd1}) begin
      n_err++; $display("FAIL clr_first got obs=%h exp in0=0 in1=3c wp1=00001 wp2=1", first);
    end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      bus.s_valid = ($urandom_range(0, 99) < 60);
      bus.s_data  = 8'($urandom);
      bus.s_last  = ($urandom_range(0, 99) < 25);
      bus.dn_en   = ($urandom_range(0, 99) < 70);
      clr         = ($urandom_range(0, 99) < 2);
      tick();
      n_vec++;
      if (dut_obs() !== exp_obs()) begin
        n_err++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_obs(), exp_obs());
      end
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_reset_mid_frame();
    test_fill();
    test_wrap();
    test_simul();
    test_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/legacy_ingress_buf.md
Name: legacy_ingress_buf

Overview:
- Ingress stage directly upstream of the legacy datapath block.
- Accepts a byte stream over a valid/ready handshake and buffers it in a small FIFO.
- Paces bytes out under a downstream enable, driving the data bus (in1-side), a per-frame address (in0-side) and the two status pattern fields (wpat1/wpat2) the downstream block consumes.
- Inserts a one-cycle bubble after each frame's last byte.

Parameters:
- AW, 4, width of the per-frame byte address; address wraps modulo 2^AW.
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear; priority over all other activity
- s_valid  input  1  upstream byte valid
- s_ready  output  1  upstream may push; equals !full
- s_data  input  8  upstream byte
- s_last  input  1  byte is the last of its frame
- dn_en  input  1  downstream accepts one byte this cycle
- out_vld  output  1  out_* registers were loaded by a pop last cycle
- out_in0  output  AW  byte address within the frame
- out_in1  output  8  byte data
- out_wpat1  output  5 ([7:3])  {frame_cnt[3:0], last_flag}
- out_wpat2  output  4 ([15:12])  FIFO fill level sampled at pop, zero-extended

Behaviour:
- Reset (rstn low, async) and clr (sync) have the same effect:
  - FIFO empty; s_ready=1.
  - All out_* = 0.
  - addr=0, frame_cnt=0, FSM=IDLE.
  - clr discards any push or pop in the same cycle.
- FIFO:
  - Entries are {last, data[7:0]}.
  - push = s_valid & s_ready.
  - Pointers are log2(DEPTH) bits, wrap naturally; fill count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: s_ready=0, no push.
  - Empty: no pop; data written this cycle is not visible to pop until the next cycle (no bypass).
- FSM states: IDLE, RUN, GAP.
  - IDLE: go to RUN when FIFO is non-empty.
  - RUN: pop = dn_en & !empty.
    - Popped last=1: go to GAP.
    - FIFO empty with no pop: go to IDLE.
  - GAP: exactly one cycle, no pop; then RUN if non-empty, else IDLE.
- On pop, all outputs register at the next edge (1-cycle pop-to-output latency):
  - out_in1 = data; out_in0 = addr.
  - out_wpat1 = {frame_cnt, last}; out_wpat2 = fill count before the pop.
  - out_vld = 1.
- addr:
  - Increments on every non-last pop; wraps from 2^AW-1 to 0 mid-frame, with no error.
  - Reset to 0 on a last pop.
- frame_cnt increments modulo 16 on each last pop; the new value first appears on the next frame's first byte.
- Cycles without a pop:
  - out_vld = 0.
  - out_in0, out_in1 and both wpat outputs hold their last values.
- Earliest output: s_valid high in cycle 0 gives out_vld high after the edge ending cycle 2, provided dn_en is held high.

Decomposition:
- Shared package legacy_pkg:
  - FSM state enum {IDLE, RUN, GAP}.
  - Byte width constant 8.
  - Frame counter width constant 4.
- One natural sub-module: legacy_sync_fifo (parameters DEPTH, W=9).
  - Ports: push, pop, wdata, rdata, full, empty, count, clr.
  - The top level holds the FSM, address/frame counters and output registers.

Test Plan:
1. Reset mid-frame.
   - Stimulus: push 3 bytes, then assert rstn low asynchronously.
   - Required: s_ready=1 and all out_*=0 immediately; the first post-reset pop shows out_in0=0 and frame_cnt=0.
2. Frame of 0x11, 0x22, 0x33 (last), dn_en=1.
   - out_in0 = 0, 1, 2.
   - out_wpat1 = 5'b00000, 00000, 00001.
   - One out_vld=0 bubble follows; the next frame's first byte shows out_wpat1[7:4]=1.
3. Fill with dn_en=0.
   - Push 5 bytes: s_ready=0 after the 4th.
   - Then dn_en=1 for one cycle: out_wpat2=4, s_ready=1 on the following cycle.
4. Address wrap with AW=4.
   - 18-byte frame: out_in0 = 0..15, 0, 1; no bubble until last.
5. Simultaneous push and pop at count=2.
   - Count stays 2; data order preserved (FIFO order check).
6. clr asserted together with s_valid and dn_en.
   - No push; outputs 0 next cycle; FSM=IDLE; frame_cnt=0.
